// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared definitions for io_bus_ctrl.
//   - byte offsets of the register map
//   - bus FSM state encoding
//   - decoded register selector and address decode helper
//   - STATUS pending bit index
package io_bus_pkg;

    localparam logic [7:0] AddrOut0   = 8'h00;
    localparam logic [7:0] AddrOut1   = 8'h04;
    localparam logic [7:0] AddrOut2   = 8'h08;
    localparam logic [7:0] AddrIn0    = 8'h0C;
    localparam logic [7:0] AddrIn1    = 8'h10;
    localparam logic [7:0] AddrStatus = 8'h14;

    localparam int unsigned StatusPendBit = 0;

    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StResp,
        StHold
    } bus_state_e;

    typedef enum logic [2:0] {
        RegOut0,
        RegOut1,
        RegOut2,
        RegIn0,
        RegIn1,
        RegStatus,
        RegNone
    } reg_sel_e;

    // Takes the word address (addr[7:2]); byte lanes are not decoded.
    function automatic reg_sel_e decode_addr(input logic [5:0] word);
        case ({word, 2'b00})
            AddrOut0:   return RegOut0;
            AddrOut1:   return RegOut1;
            AddrOut2:   return RegOut2;
            AddrIn0:    return RegIn0;
            AddrIn1:    return RegIn1;
            AddrStatus: return RegStatus;
            default:    return RegNone;
        endcase
    endfunction

endpackage

// File: rtl/io_bus_ctrl_if.sv
// io_bus_ctrl_if: CPU-side request/acknowledge bus.
//   req, we, addr[7:0], wdata[31:0]  : driven by the CPU (master)
//   rdata[31:0], ack, err            : driven by the controller (slave)
interface io_bus_ctrl_if;

    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, err
    );

endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer plus per-vector debouncer for the slide switches.
//   clk, reset (async, active-low)
//   sw_raw[9:0] : asynchronous switch levels
//   stable[9:0] : debounced switch value
//   change      : one-cycle pulse on the cycle stable is loaded with a new value
module sw_debounce #(
    parameter int unsigned DB_LIMIT = 50000,
    parameter int unsigned DB_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] sw_raw,
    output logic [9:0] stable,
    output logic       change
);

    localparam logic [DB_W-1:0] CntMax = DB_W'(DB_LIMIT - 1);

    logic [9:0]      sync1_q, sync2_q, cand_q, stable_q;
    logic [DB_W-1:0] cnt_q;
    logic            load;

    // Candidate has held for the full window and differs from what is published.
    assign load   = (sync2_q == cand_q) && (cnt_q == CntMax) && (stable_q != cand_q);
    assign change = load;
    assign stable = stable_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                // Saturate rather than wrap so a long-stable input never re-triggers.
                if (cnt_q != CntMax) begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
                if (load) begin
                    stable_q <= cand_q;
                end
            end
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped IO controller.
//   clk, reset (async, active-low)
//   bus         : CPU request/ack bus (slave side)
//   sw_raw[9:0] : asynchronous slide switches, debounced before use
//   out_port0..2: registered 32-bit display words
//   irq         : level, high while STATUS pending is set
// Map: 0x00/04/08 OUT0..2 (R/W), 0x0C IN0 = sw[9:5], 0x10 IN1 = sw[4:0],
//      0x14 STATUS bit0 pending (write 1 clears); anything else acks with err.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int unsigned DB_LIMIT = 50000,
    parameter int unsigned DB_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    io_bus_ctrl_if.slave        bus,
    input  logic [9:0]          sw_raw,
    output logic [31:0]         out_port0,
    output logic [31:0]         out_port1,
    output logic [31:0]         out_port2,
    output logic                irq
);

    bus_state_e  state_q;
    reg_sel_e    sel_q;
    logic        armed_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        ack_q, err_q;
    logic [31:0] rdata_q;
    logic [31:0] out0_q, out1_q, out2_q;
    logic        pending_q;

    logic [9:0]  sw_stable;
    logic        sw_change;
    logic        status_clr;
    logic [31:0] rd_word;

    sw_debounce #(
        .DB_LIMIT (DB_LIMIT),
        .DB_W     (DB_W)
    ) u_sw_debounce (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (sw_raw),
        .stable (sw_stable),
        .change (sw_change)
    );

    assign status_clr = (state_q == StResp) && we_q && (sel_q == RegStatus) &&
                        wdata_q[StatusPendBit];

    always_comb begin
        rd_word = '0;
        case (sel_q)
            RegOut0:   rd_word = out0_q;
            RegOut1:   rd_word = out1_q;
            RegOut2:   rd_word = out2_q;
            RegIn0:    rd_word = {27'b0, sw_stable[9:5]};
            RegIn1:    rd_word = {27'b0, sw_stable[4:0]};
            RegStatus: rd_word[StatusPendBit] = pending_q;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            armed_q   <= 1'b0;
            sel_q     <= RegNone;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            out2_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;

            // A new switch value wins over a same-cycle software clear.
            if (sw_change) begin
                pending_q <= 1'b1;
            end else if (status_clr) begin
                pending_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    // armed_q stays low after reset until req is seen low, so a
                    // request still held across reset is not replayed.
                    if (!bus.req) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q <= StLatch;
                    end
                end
                StLatch: begin
                    we_q    <= bus.we;
                    sel_q   <= decode_addr(bus.addr[7:2]);
                    wdata_q <= bus.wdata;
                    state_q <= StResp;
                end
                StResp: begin
                    ack_q   <= 1'b1;
                    state_q <= StHold;
                    if (sel_q == RegNone) begin
                        err_q <= 1'b1;
                    end else if (we_q) begin
                        case (sel_q)
                            RegOut0: out0_q <= wdata_q;
                            RegOut1: out1_q <= wdata_q;
                            RegOut2: out2_q <= wdata_q;
                            default: ;
                        endcase
                    end else begin
                        rdata_q <= rd_word;
                    end
                end
                StHold: begin
                    if (!bus.req) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign out_port0 = out0_q;
    assign out_port1 = out1_q;
    assign out_port2 = out2_q;
    assign irq       = pending_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: the driver pushes expected responses from a
// register-map model, a monitor pops and compares whenever ack is seen.
module tb_io_bus_ctrl;

    localparam int unsigned DbLimit = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  sw_raw;
    logic [31:0] out_port0, out_port1, out_port2;
    logic        irq;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          ack_edge;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_out [3];
    logic [9:0]  m_stable;
    logic        m_pend;

    io_bus_ctrl_if bus ();

    io_bus_ctrl #(
        .DB_LIMIT (DbLimit),
        .DB_W     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sw_raw    (sw_raw),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2),
        .irq       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model_access(input logic w, input logic [7:0] a,
                                          input logic [31:0] d);
        exp_t e;
        e.err      = 1'b0;
        e.rdata    = '0;
        e.ack_edge = 0;
        case (a[7:2])
            6'd0, 6'd1, 6'd2: begin
                if (w) m_out[a[3:2]] = d;
                else   e.rdata = m_out[a[3:2]];
            end
            6'd3: if (!w) e.rdata = {27'b0, m_stable[9:5]};
            6'd4: if (!w) e.rdata = {27'b0, m_stable[4:0]};
            6'd5: begin
                if (w) begin
                    if (d[0]) m_pend = 1'b0;
                end else begin
                    e.rdata = {31'b0, m_pend};
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // One full CPU transaction; ack_edge is the cycle on which ack must appear.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                        output int ack_edge);
        exp_t e;
        bit   seen;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        e = model_access(w, a, d);
        e.ack_edge = cyc + 3;
        ack_edge = e.ack_edge;
        exp_q.push_back(e);
        @(posedge clk);
        @(posedge clk);
        #2;
        // Fields are already latched; scrambling them must have no effect.
        bus.we    = 1'($urandom);
        bus.addr  = 8'($urandom);
        bus.wdata = $urandom;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.ack;
        end
        check("ack_timeout", 32'(seen), 32'd1);
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_outs();
        check("out_port0", out_port0, m_out[0]);
        check("out_port1", out_port1, m_out[1]);
        check("out_port2", out_port2, m_out[2]);
        check("irq", 32'(irq), 32'(m_pend));
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(bus.ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_err", 32'(bus.err), 32'(e.err));
                    check("ack_rdata", bus.rdata, e.rdata);
                    check("ack_latency", cyc, e.ack_edge);
                end
            end else begin
                check("idle_rdata", bus.rdata, 32'd0);
                check("idle_err", 32'(bus.err), 32'd0);
            end
        end
    end

    // Stimulus
    initial begin
        int          ae;
        int          rise;
        int          hits;
        int          acks;
        logic        exp_irq;
        logic [9:0]  v;
        logic [7:0]  a;
        logic        w;

        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        sw_raw = '0;
        reset  = 1'b0;
        foreach (m_out[i]) m_out[i] = '0;
        m_stable = '0;
        m_pend   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check_outs();
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write/read of OUT1
        xfer(1'b1, 8'h04, 32'h0000_1234, ae);
        check_outs();
        xfer(1'b0, 8'h04, 32'h0, ae);

        // Debounce of a clean edge
        @(negedge clk);
        sw_raw = 10'h3FF;
        repeat (4) @(posedge clk);
        #1;
        check("db_early_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 16 && !irq; i++) begin
            @(posedge clk);
            #1;
        end
        m_stable = 10'h3FF;
        m_pend   = 1'b1;
        check("db_irq_set", 32'(irq), 32'd1);
        xfer(1'b0, 8'h0C, 32'h0, ae);
        xfer(1'b0, 8'h10, 32'h0, ae);
        xfer(1'b0, 8'h14, 32'h0, ae);
        xfer(1'b1, 8'h14, 32'h1, ae);
        check_outs();

        // Bounce: toggle every 2 cycles for 40 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sw_raw = (i % 2 == 0) ? 10'($urandom) & 10'h3FE : 10'h3FF;
            repeat (2) begin
                @(posedge clk);
                #1;
                check("bounce_irq", 32'(irq), 32'd0);
            end
        end
        repeat (12) @(negedge clk);
        check_outs();
        xfer(1'b0, 8'h0C, 32'h0, ae);
        xfer(1'b0, 8'h10, 32'h0, ae);

        // Unmapped accesses
        xfer(1'b0, 8'h20, 32'h0, ae);
        xfer(1'b1, 8'h20, 32'hFFFF_FFFF, ae);
        check_outs();

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 7) * 4) | 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = 8'($urandom);
            w = 1'($urandom);
            xfer(w, a, $urandom, ae);
            check_outs();
        end

        // Set/clear race sweep: slide the STATUS clear across the set edge
        hits = 0;
        for (int j = 0; j < 11; j++) begin
            v = ~m_stable;
            @(negedge clk);
            sw_raw = v;
            rise = -1;
            fork
                begin
                    for (int t = 0; t < 30; t++) begin
                        @(posedge clk);
                        #1;
                        if (irq && rise < 0) rise = cyc;
                    end
                end
                begin
                    repeat (j) @(negedge clk);
                    xfer(1'b1, 8'h14, 32'h1, ae);
                end
            join
            m_stable = v;
            check("sweep_rise_seen", 32'(rise >= 0), 32'd1);
            exp_irq = (ae <= rise);
            if (ae == rise) hits++;
            m_pend = exp_irq;
            check_outs();
            if (m_pend) xfer(1'b1, 8'h14, 32'h1, ae);
            check_outs();
        end
        check("sweep_coincide", 32'(hits > 0), 32'd1);

        // Reset in LATCH during a write to OUT0
        @(negedge clk);
        sw_raw    = '0;
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 8'h00;
        bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        foreach (m_out[i]) m_out[i] = '0;
        m_stable = '0;
        m_pend   = 1'b0;
        check_outs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack) acks++;
        end
        check("rst_no_ack", acks, 32'd0);
        check_outs();
        @(negedge clk);
        bus.req = 1'b0;
        xfer(1'b1, 8'h00, 32'hCAFE_0001, ae);
        check_outs();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/io_bus_ctrl.md
IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 SHALL have parameter DB_LIMIT, default 50000, giving debounce stable-cycle count (1 ms at 50 MHz).
REQ-002 SHALL have parameter DB_W, default 16, giving debounce counter width; DB_LIMIT <= 2^DB_W - 1.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  CPU bus access request, held high until ack seen.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with addr/wdata.
REQ-007 SHALL have port addr  input  8  byte offset; addr[1:0] ignored.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  read data, valid while ack high.
REQ-010 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  one-cycle pulse coincident with ack for an unmapped address.
REQ-012 SHALL have port sw_raw  input  10  asynchronous slide-switch levels.
REQ-013 SHALL have ports out_port0, out_port1, out_port2  output  32 each  registered display words.
REQ-014 SHALL have port irq  output  1  level, high while status pending bit set.

Function
REQ-015 SHALL decode the map: 0x00 OUT0, 0x04 OUT1, 0x08 OUT2 (R/W); 0x0C IN0 = {27'b0, sw[9:5]} (RO); 0x10 IN1 = {27'b0, sw[4:0]} (RO); 0x14 STATUS, bit0 = pending (read; write 1 clears); all else unmapped.
REQ-016 SHALL run FSM IDLE -> LATCH -> RESP -> HOLD -> IDLE: IDLE leaves when req=1; LATCH captures we/addr/wdata; RESP asserts ack for exactly one cycle and performs the write; HOLD waits for req=0.
REQ-017 SHALL assert ack exactly 2 cycles after the first clock edge sampling req=1 in IDLE.
REQ-018 SHALL ignore changes of addr/we/wdata after LATCH.
REQ-019 SHALL accept no new request until req has been observed low in HOLD; back-to-back requests need a req low cycle.
REQ-020 SHALL drive rdata = 0 whenever ack = 0 and for writes and unmapped accesses.
REQ-021 SHALL ignore writes to IN0/IN1 (ack, no err); unmapped read or write SHALL give ack with err and change no state.
REQ-022 SHALL pass sw_raw through a 2-flop synchronizer before any use.
REQ-023 SHALL debounce: when synced != candidate, load candidate and clear counter; else count up, and on reaching DB_LIMIT-1 with stable != candidate, load stable and set pending.
REQ-024 SHALL saturate the debounce counter at DB_LIMIT-1 with no wrap.
REQ-025 SHALL give set priority over clear when a pending set and a STATUS write-1 clear occur in the same cycle.
REQ-026 SHALL source IN0/IN1 reads from stable, never from raw or synced values.

Reset
REQ-027 SHALL, on reset low, immediately (asynchronously) force FSM IDLE, ack=0, err=0, rdata=0, out_port0..2=0, pending=0, irq=0, sync flops/candidate/stable=0, and counter=0.
REQ-028 SHALL, on reset asserted mid-transaction, abort it with no ack and no register write; after release the CPU must drop and re-raise req.

Structure
REQ-029 SHALL take address offsets, FSM state encoding and the STATUS bit index from shared package io_bus_pkg.
REQ-030 SHALL put the synchronizer and debounce logic in sub-module sw_debounce (10-bit vector, parameters DB_LIMIT, DB_W), outputting stable and a one-cycle change pulse.

Verification (DB_LIMIT=4)
REQ-031 SHALL cover: write 0x0000_1234 to 0x04 -> ack 2 cycles after req, out_port1=0x1234, err=0; read 0x04 -> rdata=0x1234.
REQ-032 SHALL cover: sw_raw 0 -> 0x3FF held -> after 2 sync + 4 stable cycles, IN0=0x1F, IN1=0x1F, irq=1; write 0x1 to 0x14 -> irq=0.
REQ-033 SHALL cover: sw_raw toggling every 2 cycles for 40 cycles -> stable unchanged, irq stays 0.
REQ-034 SHALL cover: read 0x20 -> ack with err=1 and rdata=0; write 0x20 -> outputs unchanged.
REQ-035 SHALL cover: pending set and STATUS clear in the same cycle -> irq=1 afterwards.
REQ-036 SHALL cover: reset asserted in LATCH during a write to 0x00 -> no ack, out_port0=0; after release with req held high -> no ack until req low then high.
